// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between NUM_REQ writeback
// sources, with a post-reset sweep that zeroes x1..x(2^ADDR_W-1).
module regfile_write_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [2:0]                grant_id,
  output logic                      busy
);

  typedef enum logic {S_CLEAR, S_ARB} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] FIRST_IDX = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [2:0]          rr_ptr;
  logic [2:0]          next_ptr;
  int                  scan_idx;

  logic                vld_p0;
  logic [2:0]          gnt_idx_p0;
  logic [ADDR_W-1:0]   gnt_rd_p0;
  logic [DATA_W-1:0]   gnt_data_p0;

  // Stage p0: combinational round-robin search starting at rr_ptr
  always_comb begin
    req_ready   = '0;
    vld_p0      = 1'b0;
    gnt_idx_p0  = '0;
    gnt_rd_p0   = '0;
    gnt_data_p0 = '0;
    scan_idx    = 0;
    if (state == S_ARB) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
        if (!vld_p0 && req_valid[scan_idx]) begin
          vld_p0              = 1'b1;
          gnt_idx_p0          = 3'(scan_idx);
          gnt_rd_p0           = req_rd[scan_idx*ADDR_W +: ADDR_W];
          gnt_data_p0         = req_data[scan_idx*DATA_W +: DATA_W];
          req_ready[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign next_ptr = (gnt_idx_p0 == 3'(NUM_REQ-1)) ? 3'd0 : gnt_idx_p0 + 3'd1;

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && cnt == LAST_IDX) state_nxt = S_ARB;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR_ON_RESET ? S_CLEAR : S_ARB;
    else       state <= state_nxt;
  end

  assign busy = (state == S_CLEAR);

  // Stage p1: registered write port; x0 writes are consumed but never enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= FIRST_IDX;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (state == S_CLEAR) begin
      rf_we    <= 1'b1;
      rf_rd    <= cnt;
      rf_wdata <= '0;
      cnt      <= cnt + FIRST_IDX;
    end else if (vld_p0) begin
      rf_we    <= (gnt_rd_p0 != '0);
      rf_rd    <= gnt_rd_p0;
      rf_wdata <= gnt_data_p0;
      grant_id <= gnt_idx_p0;
      rr_ptr   <= next_ptr;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: per-cycle compare against a behavioural
// model plus hand-computed literal expectations.
module tb_regfile_write_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int LAST = (1 << AW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [DW-1:0]   rf_wdata;
  logic [2:0]      grant_id;
  logic            busy;

  int checks = 0;
  int failures = 0;

  regfile_write_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .grant_id(grant_id), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: clear sweep index, round-robin pointer, expected write port.
  int          m_next_clear;
  int          m_rr;
  bit          m_we;
  int          m_rd;
  logic [31:0] m_wdata;
  int          m_gid;

  function automatic int m_pick();
    if (m_next_clear <= LAST) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    int g;
    if (reset) begin
      m_next_clear = 1; m_rr = 0; m_we = 0; m_rd = 0; m_wdata = 0; m_gid = 0;
    end else if (m_next_clear <= LAST) begin
      m_we = 1; m_rd = m_next_clear; m_wdata = 0; m_next_clear++;
    end else begin
      g = m_pick();
      if (g >= 0) begin
        m_rd    = int'(req_rd[g*AW +: AW]);
        m_wdata = req_data[g*DW +: DW];
        m_we    = (m_rd != 0);
        m_gid   = g;
        m_rr    = (g + 1) % NREQ;
      end else begin
        m_we = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] exp_ready;
    g = m_pick();
    exp_ready = (g < 0) ? '0 : NREQ'(1 << g);
    chk("cmp_rf_we", 32'(rf_we), 32'(m_we));
    chk("cmp_rf_rd", 32'(rf_rd), 32'(m_rd));
    chk("cmp_rf_wdata", rf_wdata, m_wdata);
    chk("cmp_grant_id", 32'(grant_id), 32'(m_gid));
    chk("cmp_busy", 32'(busy), 32'(m_next_clear <= LAST));
    chk("cmp_req_ready", 32'(req_ready), 32'(exp_ready));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    req_rd[i*AW +: AW]   = rd;
    req_data[i*DW +: DW] = data;
  endtask

  initial begin
    bit found;
    reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_grant_id", 32'(grant_id), 32'd0);

    // 1: clear sweep, requests held high to prove nothing is granted
    reset = 1'b0;
    req_valid = 3'b111;
    for (int i = 1; i <= LAST; i++) begin
      tick();
      chk("clr_rf_we", 32'(rf_we), 32'd1);
      chk("clr_rf_rd", 32'(rf_rd), 32'(i));
      chk("clr_rf_wdata", rf_wdata, 32'd0);
      chk("clr_busy", 32'(busy), (i == LAST) ? 32'd0 : 32'd1);
      if (i < LAST) chk("clr_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = '0;

    // 2: single request from req0
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1 chk("t2_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    chk("t2_we", 32'(rf_we), 32'd1);
    chk("t2_rd", 32'(rf_rd), 32'd5);
    chk("t2_wdata", rf_wdata, 32'hDEADBEEF);
    chk("t2_gid", 32'(grant_id), 32'd0);

    // 4: x0 write is accepted but not enabled; pointer moves to 2
    set_req(1, 5'd0, 32'h1234);
    req_valid = 3'b010;
    #1 chk("t4_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = 3'b111;
    chk("t4_we", 32'(rf_we), 32'd0);
    chk("t4_gid", 32'(grant_id), 32'd1);
    #1 chk("t4_rr_is_2", 32'(req_ready), 32'b100);
    req_valid = '0;

    // 6: req2 alone four times, then req0+req2
    set_req(2, 5'd7, 32'hA2);
    req_valid = 3'b100;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t6_ready2", 32'(req_ready), 32'b100);
      tick();
      chk("t6_gid2", 32'(grant_id), 32'd2);
      chk("t6_rd2", 32'(rf_rd), 32'd7);
    end
    set_req(0, 5'd8, 32'hA0);
    req_valid = 3'b101;
    #1 chk("t6_ready0", 32'(req_ready), 32'b001);
    tick();
    chk("t6_gid0", 32'(grant_id), 32'd0);
    chk("t6_rd0", 32'(rf_rd), 32'd8);
    req_valid = 3'b100;
    #1 chk("t6_ready2b", 32'(req_ready), 32'b100);
    tick();
    chk("t6_gid2b", 32'(grant_id), 32'd2);
    req_valid = '0;

    // 3: all three continuously valid
    set_req(0, 5'd1, 32'h10);
    set_req(1, 5'd2, 32'h20);
    set_req(2, 5'd3, 32'h30);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("t3_ready", 32'(req_ready), 32'(1 << (i % 3)));
      tick();
      chk("t3_gid", 32'(grant_id), 32'(i % 3));
      chk("t3_rd", 32'(rf_rd), 32'(i % 3 + 1));
      chk("t3_we", 32'(rf_we), 32'd1);
    end
    req_valid = '0;
    tick();
    chk("idle_we", 32'(rf_we), 32'd0);
    chk("idle_rd_hold", 32'(rf_rd), 32'd3);
    chk("idle_wdata_hold", rf_wdata, 32'h30);

    // 5: reset in the middle of a clear sweep
    reset = 1'b1;
    tick();
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (rf_rd == 5'd10) found = 1'b1;
    end
    chk("t5_reach_rd10", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_we", 32'(rf_we), 32'd0);
    chk("t5_async_rd", 32'(rf_rd), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    chk("t5_restart_rd", 32'(rf_rd), 32'd1);
    chk("t5_restart_we", 32'(rf_we), 32'd1);
    tick();
    chk("t5_restart_rd2", 32'(rf_rd), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
